// File: rtl/stim_resp_tester.sv
// Stimulus/response latency tester for QD1.
// Pulses stimulus, times each response rising edge, keeps pass/timeout/min/max/last.
module stim_resp_tester #(
  parameter int PULSE_GAP = 4,
  parameter int TIMEOUT   = 1000,
  parameter int NUM_TESTS = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk_50_clk,
  input  logic             reset_reset_n,
  input  logic             start,
  input  logic             response_in,
  output logic             stimulus_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] min_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [7:0]       pass_count,
  output logic [7:0]       timeout_count
);

  localparam int GW = $clog2(PULSE_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, GAP, STIM, NEXT, FIN
  } state_t;

  state_t           state_q;
  logic             resp_q;
  logic             stim_q;
  logic             busy_q;
  logic             done_q;
  logic [GW-1:0]    gap_q;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] lat_d;
  logic [7:0]       trial_q;
  logic [7:0]       trial_d;
  logic [CNT_W-1:0] last_q;
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] max_q;
  logic [7:0]       pass_q;
  logic [7:0]       tout_q;
  logic             resp_edge;

  assign resp_edge = response_in & ~resp_q;
  // lat_d is the edge count since the stimulus rose
  assign lat_d     = lat_q + 1'b1;
  assign trial_d   = trial_q + 8'd1;

  always_ff @(posedge clk_50_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      stim_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
      lat_q   <= '0;
      trial_q <= '0;
      last_q  <= '0;
      min_q   <= '1;
      max_q   <= '0;
      pass_q  <= '0;
      tout_q  <= '0;
    end else begin
      resp_q <= response_in;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            last_q  <= '0;
            min_q   <= '1;
            max_q   <= '0;
            pass_q  <= '0;
            tout_q  <= '0;
            trial_q <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          stim_q <= 1'b0;
          if (gap_q == GW'(PULSE_GAP - 1)) begin
            stim_q  <= 1'b1;
            lat_q   <= '0;
            state_q <= STIM;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        STIM: begin
          lat_q <= lat_d;
          if (resp_edge) begin
            last_q  <= lat_d;
            pass_q  <= pass_q + 8'd1;
            stim_q  <= 1'b0;
            state_q <= NEXT;
            if (lat_d < min_q) min_q <= lat_d;
            if (lat_d > max_q) max_q <= lat_d;
          end else if (lat_d == CNT_W'(TIMEOUT)) begin
            tout_q  <= tout_q + 8'd1;
            stim_q  <= 1'b0;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          trial_q <= trial_d;
          if (trial_d == 8'(NUM_TESTS)) begin
            state_q <= FIN;
          end else begin
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stimulus_out  = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign last_latency  = last_q;
  assign min_latency   = min_q;
  assign max_latency   = max_q;
  assign pass_count    = pass_q;
  assign timeout_count = tout_q;

endmodule

// File: tb/tb_stim_resp_tester.sv
// Scoreboard bench for stim_resp_tester.
// Directed runs push expected results; a negedge monitor pops and compares.
module tb_stim_resp_tester;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        response_in = 1'b0;
  logic        stimulus_out;
  logic        busy;
  logic        done;
  logic [15:0] last_latency;
  logic [15:0] min_latency;
  logic [15:0] max_latency;
  logic [7:0]  pass_count;
  logic [7:0]  timeout_count;

  always #5 clk = ~clk;

  stim_resp_tester #(
    .PULSE_GAP(4),
    .TIMEOUT(TO),
    .NUM_TESTS(3),
    .CNT_W(16)
  ) dut (
    .clk_50_clk(clk),
    .reset_reset_n(rst_n),
    .start(start),
    .response_in(response_in),
    .stimulus_out(stimulus_out),
    .busy(busy),
    .done(done),
    .last_latency(last_latency),
    .min_latency(min_latency),
    .max_latency(max_latency),
    .pass_count(pass_count),
    .timeout_count(timeout_count)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  tc;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] ls;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] ex;
  } chk_t;

  exp_t sq[$];
  int   wq[$];
  chk_t dq[$];

  int n_chk = 0;
  int n_fail = 0;
  int ndone = 0;
  bit chk_w = 1'b1;
  bit stuck = 1'b0;
  int lats[3];
  int tidx = 0;
  int k = 0;

  task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Responder: raise response_in when stimulus has been high lats[t] edges
  always @(posedge clk) begin
    #1;
    if (start) tidx = 0;
    if (stimulus_out) k++;
    else begin
      if (k > 0) tidx++;
      k = 0;
    end
    if (stuck) response_in = 1'b1;
    else if (!stimulus_out) response_in = 1'b0;
    else if (tidx < 3 && lats[tidx] != 0 && k == lats[tidx])
      response_in = 1'b1;
  end

  // Monitor
  int   w = 0;
  int   we;
  exp_t e_m;
  chk_t c_m;
  always @(negedge clk) begin
    while (dq.size() > 0) begin
      c_m = dq.pop_front();
      cmp(c_m.nm, c_m.act, c_m.ex);
    end
    if (stimulus_out) w++;
    else if (w > 0) begin
      if (chk_w) begin
        we = (wq.size() > 0) ? wq.pop_front() : -1;
        cmp("stim_width", w, we);
      end
      w = 0;
    end
    if (done) begin
      ndone++;
      if (sq.size() == 0) cmp("done_unexp", {31'd0, done}, 0);
      else begin
        e_m = sq.pop_front();
        cmp("pass_count", pass_count, e_m.pc);
        cmp("timeout_count", timeout_count, e_m.tc);
        cmp("min_latency", min_latency, e_m.mn);
        cmp("max_latency", max_latency, e_m.mx);
        cmp("last_latency", last_latency, e_m.ls);
        cmp("busy_at_done", busy, 0);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    dq.push_back('{nm, a, e});
  endtask

  task automatic run(int a, int b, int c, bit s, exp_t e);
    int d0;
    int cyc;
    lats = '{a, b, c};
    stuck = s;
    sq.push_back(e);
    for (int i = 0; i < 3; i++)
      wq.push_back((s || lats[i] < 1 || lats[i] > TO) ? TO : lats[i]);
    d0 = ndone;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_run", busy, 1);
    cyc = 0;
    while (ndone == d0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (ndone == d0) chk("run_timeout", done, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    lats = '{0, 0, 0};
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stim", stimulus_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_min", min_latency, 16'hFFFF);
    chk("rst_max", max_latency, 0);
    chk("rst_last", last_latency, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_tout", timeout_count, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy_hold", busy, 0);

    run(7, 7, 7, 1'b0, '{pc: 3, tc: 0, mn: 7, mx: 7, ls: 7});
    run(3, 12, 5, 1'b0, '{pc: 3, tc: 0, mn: 3, mx: 12, ls: 5});
    run(20, 0, 21, 1'b0, '{pc: 1, tc: 2, mn: 20, mx: 20, ls: 20});
    run(0, 0, 0, 1'b1, '{pc: 0, tc: 3, mn: 16'hFFFF, mx: 0, ls: 0});
    stuck = 1'b0;
    repeat (3) @(negedge clk);

    chk_w = 1'b0;
    lats = '{7, 0, 0};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(tidx == 1 && stimulus_out) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach_stim2", stimulus_out, 1);
    repeat (3) @(negedge clk);
    chk("abort_pre_pass", pass_count, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_stim", stimulus_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pass", pass_count, 0);
    chk("abort_min", min_latency, 16'hFFFF);
    chk("abort_max", max_latency, 0);
    chk("abort_last", last_latency, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_w = 1'b1;

    run(7, 7, 7, 1'b0, '{pc: 3, tc: 0, mn: 7, mx: 7, ls: 7});
    repeat (3) @(negedge clk);
    chk("sb_left", sq.size(), 0);
    chk("width_left", wq.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
